// File: rtl/bcd_display_mux_if.sv
// Load handshake and display pin bundle for bcd_display_mux.
// The slave modport is the driver side; the master modport is the datapath/bench side.
interface bcd_display_mux_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] bcd_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  load_valid;
  logic                  load_ready;
  logic                  lzb_en;
  logic [6:0]            seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_tick;

  modport master (
    output bcd_in, dp_in, load_valid, lzb_en,
    input  load_ready, seg, dp, an, frame_tick
  );

  modport slave (
    input  bcd_in, dp_in, load_valid, lzb_en,
    output load_ready, seg, dp, an, frame_tick
  );
endinterface

// File: rtl/bcd_display_mux.sv
// Time-multiplexed BCD to 7-segment driver with leading-zero blanking,
// decimal points, an anti-ghosting gap and frame-synchronous display updates.
module bcd_display_mux #(
  parameter int N_DIGITS    = 4,
  parameter int SCAN_DIV    = 1000,
  parameter int BLANK_CYC   = 2,
  parameter int SEG_ACT_LOW = 0,
  parameter int AN_ACT_LOW  = 0
) (
  input logic              clk,
  input logic              rst,
  bcd_display_mux_if.slave bus
);

  // state   | meaning
  // ST_RUN  | idle, load_ready=1, a load is captured into the shadow regs
  // ST_PEND | shadow holds a load waiting for the next frame boundary
  typedef enum logic {ST_RUN, ST_PEND} state_t;

  localparam int   PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int   IW      = $clog2(N_DIGITS);
  localparam logic SEG_INV = (SEG_ACT_LOW != 0);
  localparam logic AN_INV  = (AN_ACT_LOW != 0);

  state_t                state_q, state_d;
  logic [PW-1:0]         presc_q;
  logic [IW-1:0]         idx_q;
  logic [4*N_DIGITS-1:0] disp_q, shadow_q;
  logic [N_DIGITS-1:0]   disp_dp_q, shadow_dp_q;
  logic                  slot_end, boundary, capture, apply;
  logic [N_DIGITS-1:0]   hi_zero;
  logic [3:0]            cur_code;
  logic [6:0]            seg_nxt;
  logic [N_DIGITS-1:0]   an_nxt;

  assign slot_end = (presc_q == PW'(SCAN_DIV - 1));
  assign boundary = slot_end && (idx_q == IW'(N_DIGITS - 1));
  assign bus.load_ready = (state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    apply   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (bus.load_valid) begin
          capture = 1'b1;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (boundary) begin
          apply   = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // hi_zero[i]: every digit from the most significant down to i is zero
  always_comb begin
    hi_zero = '0;
    hi_zero[N_DIGITS-1] = (disp_q[4*N_DIGITS-1 -: 4] == 4'd0);
    for (int i = N_DIGITS - 2; i >= 0; i--)
      hi_zero[i] = hi_zero[i+1] && (disp_q[4*i +: 4] == 4'd0);
  end

  always_comb begin
    cur_code = disp_q[{idx_q, 2'b00} +: 4];
    case (cur_code)
      4'd0:    seg_nxt = 7'h7E;
      4'd1:    seg_nxt = 7'h30;
      4'd2:    seg_nxt = 7'h6D;
      4'd3:    seg_nxt = 7'h79;
      4'd4:    seg_nxt = 7'h33;
      4'd5:    seg_nxt = 7'h5B;
      4'd6:    seg_nxt = 7'h5F;
      4'd7:    seg_nxt = 7'h70;
      4'd8:    seg_nxt = 7'h7F;
      4'd9:    seg_nxt = 7'h7B;
      default: seg_nxt = 7'h00;
    endcase
    if (bus.lzb_en && (idx_q != '0) && hi_zero[idx_q])
      seg_nxt = 7'h00;
  end

  always_comb begin
    an_nxt = '0;
    if (presc_q >= PW'(BLANK_CYC))
      an_nxt[idx_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      presc_q        <= '0;
      idx_q          <= '0;
      disp_q         <= '0;
      shadow_q       <= '0;
      disp_dp_q      <= '0;
      shadow_dp_q    <= '0;
      bus.seg        <= {7{SEG_INV}};
      bus.dp         <= SEG_INV;
      bus.an         <= {N_DIGITS{AN_INV}};
      bus.frame_tick <= 1'b0;
    end else begin
      state_q <= state_d;
      if (slot_end) begin
        presc_q <= '0;
        idx_q   <= (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end else begin
        presc_q <= presc_q + PW'(1);
      end
      if (capture) begin
        shadow_q    <= bus.bcd_in;
        shadow_dp_q <= bus.dp_in;
      end
      if (apply) begin
        disp_q    <= shadow_q;
        disp_dp_q <= shadow_dp_q;
      end
      bus.seg        <= seg_nxt ^ {7{SEG_INV}};
      bus.dp         <= disp_dp_q[idx_q] ^ SEG_INV;
      bus.an         <= an_nxt ^ {N_DIGITS{AN_INV}};
      bus.frame_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux: 4 digits, 4-cycle slots, 1-cycle gap, plus an
// inverted-polarity instance, checked against a frame-arithmetic model.
module tb_bcd_display_mux;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_display_mux_if #(.N_DIGITS(4)) if1 ();
  bcd_display_mux_if #(.N_DIGITS(4)) if2 ();

  bcd_display_mux #(.N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .SEG_ACT_LOW(0), .AN_ACT_LOW(0))
    dut (.clk(clk), .rst(rst), .bus(if1));
  bcd_display_mux #(.N_DIGITS(4), .SCAN_DIV(4), .BLANK_CYC(1), .SEG_ACT_LOW(1), .AN_ACT_LOW(1))
    dut_inv (.clk(clk), .rst(rst), .bus(if2));

  int errors = 0;
  int checks = 0;

  // Reference model: m_c counts clock edges since reset, so the slot position
  // is m_c%4, the digit is (m_c/4)%4 and a frame boundary is m_c%16==15.
  int unsigned m_c;
  bit          m_pend;
  int          m_disp[4];
  int          m_sh[4];
  bit [3:0]    m_dpd, m_dps;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an;
  logic        exp_tick;

  function automatic logic [6:0] seg_of(input int code);
    case (code)
      0: return 7'h7E;  1: return 7'h30;  2: return 7'h6D;  3: return 7'h79;
      4: return 7'h33;  5: return 7'h5B;  6: return 7'h5F;  7: return 7'h70;
      8: return 7'h7F;  9: return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [6:0] model_seg(input logic lzb);
    int  dg;
    bit  all_zero;
    dg = int'((m_c / 4) % 4);
    if (lzb && dg > 0) begin
      all_zero = 1'b1;
      for (int j = dg; j < 4; j++) if (m_disp[j] != 0) all_zero = 1'b0;
      if (all_zero) return 7'h00;
    end
    return seg_of(m_disp[dg]);
  endfunction

  // Digit whose data is on the pins right now (pins lag the scan by one edge)
  function automatic int shown_dig();
    return int'(((m_c - 1) / 4) % 4);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_c      <= 0;
      m_pend   <= 1'b0;
      m_disp   <= '{default: 0};
      m_sh     <= '{default: 0};
      m_dpd    <= '0;
      m_dps    <= '0;
      exp_seg  <= 7'h00;
      exp_dp   <= 1'b0;
      exp_an   <= 4'b0000;
      exp_tick <= 1'b0;
    end else begin
      exp_seg  <= model_seg(if1.lzb_en);
      exp_dp   <= m_dpd[(m_c / 4) % 4];
      exp_an   <= ((m_c % 4) >= 1) ? (4'b0001 << ((m_c / 4) % 4)) : 4'b0000;
      exp_tick <= ((m_c % 16) == 15);
      if (!m_pend && if1.load_valid) begin
        for (int j = 0; j < 4; j++) m_sh[j] <= int'(if1.bcd_in[4*j +: 4]);
        m_dps  <= if1.dp_in;
        m_pend <= 1'b1;
      end else if (m_pend && (m_c % 16) == 15) begin
        m_disp <= m_sh;
        m_dpd  <= m_dps;
        m_pend <= 1'b0;
      end
      m_c <= m_c + 1;
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d);
    int n = 0;
    @(negedge clk);
    while (m_pend && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (if1.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_ready_before_load: got %b want 1", if1.load_ready);
    end
    if1.bcd_in = b; if1.dp_in = d; if1.load_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if1.load_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] want_an;
    idle(6);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (if1.an !== 4'b0000 || if1.seg !== 7'h00 || if1.dp !== 1'b0 || if1.frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_pins: an=%b seg=%h dp=%b tick=%b want 0000/00/0/0", if1.an, if1.seg, if1.dp, if1.frame_tick);
    end
    checks++;
    if (if1.load_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", if1.load_ready);
    end
    checks++;
    if (if2.seg !== 7'h7F || if2.an !== 4'b1111 || if2.dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_inv_pins: seg=%h an=%b dp=%b want 7f/1111/1", if2.seg, if2.an, if2.dp);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      want_an = (((k - 1) % 4) >= 1) ? (4'b0001 << ((k - 1) / 4)) : 4'b0000;
      checks++;
      if (if1.an !== want_an) begin
        errors++; $display("FAIL reset_scan k=%0d: an=%b want %b", k, if1.an, want_an);
      end
      checks++;
      if (if1.frame_tick !== (k == 16)) begin
        errors++; $display("FAIL reset_tick k=%0d: got %b want %b", k, if1.frame_tick, k == 16);
      end
    end
  endtask

  task automatic test_slot_timing();
    int hi[4] = '{0, 0, 0, 0};
    int ticks = 0;
    int last_tick = -1;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      checks++;
      if (if1.an !== exp_an || if1.frame_tick !== exp_tick) begin
        errors++;
        $display("FAIL slot_model k=%0d: an=%b tick=%b want %b/%b", k, if1.an, if1.frame_tick, exp_an, exp_tick);
      end
      for (int b = 0; b < 4; b++) if (if1.an[b] === 1'b1) hi[b]++;
      if (if1.frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          checks++;
          if (k - last_tick != 16) begin
            errors++; $display("FAIL tick_spacing: got %0d want 16", k - last_tick);
          end
        end
        last_tick = k;
        ticks++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (hi[b] != 9) begin
        errors++; $display("FAIL an_duty bit%0d: high %0d cycles want 9", b, hi[b]);
      end
    end
    checks++;
    if (ticks != 3) begin
      errors++; $display("FAIL tick_count: got %0d want 3", ticks);
    end
  endtask

  task automatic test_decode();
    logic [6:0] tbl[4] = '{7'h79, 7'h6D, 7'h30, 7'h7E};
    int dg;
    if1.lzb_en = 1'b0;
    do_load(16'h0123, 4'b0000);
    idle(40);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      dg = shown_dig();
      checks++;
      if (if1.seg !== tbl[dg] || if1.dp !== 1'b0) begin
        errors++; $display("FAIL decode d%0d: seg=%h dp=%b want %h/0", dg, if1.seg, if1.dp, tbl[dg]);
      end
    end
  endtask

  task automatic test_lzb();
    logic [6:0] tbl[4] = '{7'h79, 7'h6D, 7'h00, 7'h00};
    logic [3:0] dpm = 4'b0100;
    int dg;
    if1.lzb_en = 1'b1;
    do_load(16'h0023, 4'b0100);
    idle(40);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      dg = shown_dig();
      checks++;
      if (if1.seg !== tbl[dg] || if1.dp !== dpm[dg]) begin
        errors++;
        $display("FAIL lzb d%0d: seg=%h dp=%b want %h/%b", dg, if1.seg, if1.dp, tbl[dg], dpm[dg]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [6:0] tbl[4] = '{7'h7E, 7'h00, 7'h00, 7'h00};
    int dg;
    if1.lzb_en = 1'b1;
    do_load(16'h00A0, 4'b0000);
    idle(40);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      dg = shown_dig();
      checks++;
      if (if1.seg !== tbl[dg]) begin
        errors++; $display("FAIL invalid_code d%0d: seg=%h want %h", dg, if1.seg, tbl[dg]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    if1.lzb_en = 1'b0;
    @(negedge clk);
    while ((m_pend || (m_c % 16) != 2) && n < 64) begin @(negedge clk); n++; end
    if1.bcd_in = 16'h1111; if1.dp_in = 4'b0000; if1.load_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (if1.load_ready !== 1'b0) begin
      errors++; $display("FAIL pend_ready: got %b want 0", if1.load_ready);
    end
    if1.bcd_in = 16'h2222;
    idle(4);
    if1.load_valid = 1'b0;
    idle(40);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (if1.seg !== 7'h30) begin
        errors++; $display("FAIL ignore_pending d%0d: seg=%h want 30", shown_dig(), if1.seg);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] b;
    for (int it = 0; it < 6; it++) begin
      for (int j = 0; j < 4; j++) b[4*j +: 4] = 4'($urandom_range(0, (it % 2 == 0) ? 15 : 3));
      if1.lzb_en = 1'($urandom_range(0, 1));
      do_load(b, 4'($urandom_range(0, 15)));
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        checks++;
        if (if1.seg !== exp_seg || if1.dp !== exp_dp || if1.an !== exp_an ||
            if1.frame_tick !== exp_tick || if1.load_ready !== !m_pend) begin
          errors++;
          $display("FAIL random it=%0d k=%0d: seg=%h dp=%b an=%b tick=%b rdy=%b want %h/%b/%b/%b/%b",
                   it, k, if1.seg, if1.dp, if1.an, if1.frame_tick, if1.load_ready,
                   exp_seg, exp_dp, exp_an, exp_tick, !m_pend);
        end
        if (k == 30) if1.lzb_en = ~if1.lzb_en;
      end
    end
  endtask

  task automatic test_polarity();
    @(negedge clk);
    checks++;
    if (if2.load_ready !== 1'b1) begin
      errors++; $display("FAIL inv_ready: got %b want 1", if2.load_ready);
    end
    if2.bcd_in = 16'h8888; if2.dp_in = 4'b0000; if2.load_valid = 1'b1;
    @(negedge clk);
    if2.load_valid = 1'b0;
    idle(40);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if (if2.seg !== 7'h00 || if2.dp !== 1'b1 || if2.an !== ~exp_an) begin
        errors++;
        $display("FAIL inv_polarity k=%0d: seg=%h dp=%b an=%b want 00/1/%b", k, if2.seg, if2.dp, if2.an, ~exp_an);
      end
    end
  endtask

  initial begin
    if1.bcd_in = '0; if1.dp_in = '0; if1.load_valid = 1'b0; if1.lzb_en = 1'b0;
    if2.bcd_in = '0; if2.dp_in = '0; if2.load_valid = 1'b0; if2.lzb_en = 1'b0;
    idle(3);
    rst = 1'b0;
    test_reset();
    test_slot_timing();
    test_decode();
    test_lzb();
    test_invalid();
    test_back_to_back();
    test_random();
    test_polarity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
